// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS main control unit.
// Sequences the shared ALU, PC, IR, register file and memory port over
// several cycles per instruction. Moore machine. Every output decodes from the
// current state. Final-cycle memory strobes are further gated by the wait counter.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   w_opcode        IR[31:26]
//   w_funct         IR[5:0], checked only for R-type legality
//   w_zero          ALU zero flag (consumed by the datapath PC-load gate)
//   w_PCWrite ..    datapath write strobes
//   w_ALUSrcA/B     ALU operand selects
//   w_ALUOp         00=add, 01=sub, 10=decode funct
//   w_PCSource      00=ALU, 01=ALUOut, 10=jump target
//   w_illegal       sticky illegal-instruction flag
//   w_state         current state code, for debug
module mc_control_fsm #(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] w_opcode,
  input  logic [5:0] w_funct,
  input  logic       w_zero,
  output logic       w_PCWrite,
  output logic       w_PCWriteCond,
  output logic       w_IorD,
  output logic       w_MemRead,
  output logic       w_MemWrite,
  output logic       w_IRWrite,
  output logic       w_MDRWrite,
  output logic       w_RegDst,
  output logic       w_MemtoReg,
  output logic       w_RegWrite,
  output logic [1:0] w_ALUSrcA,
  output logic [1:0] w_ALUSrcB,
  output logic [1:0] w_ALUOp,
  output logic [1:0] w_PCSource,
  output logic       w_illegal,
  output logic [3:0] w_state
);

  typedef enum logic [3:0] {
    ST_RST       = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_RD    = 4'd4,
    ST_LW_WB     = 4'd5,
    ST_MEM_WR    = 4'd6,
    ST_R_EXEC    = 4'd7,
    ST_R_WB      = 4'd8,
    ST_ADDI_EXEC = 4'd9,
    ST_ADDI_WB   = 4'd10,
    ST_BRANCH    = 4'd11,
    ST_JUMP      = 4'd12,
    ST_ILLEGAL   = 4'd13,
    ST_UNUSED14  = 4'd14,
    ST_UNUSED15  = 4'd15
  } state_t;

  localparam logic [3:0] LP_WAIT_LAST = 4'(MEM_WAIT - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_wait_cnt;
  logic [3:0] w_next_wait;
  logic       r_illegal;
  logic       w_last_wait;
  logic       w_unused_zero;

  // The branch decision is taken in the datapath, so the zero flag is not needed here.
  assign w_unused_zero = w_zero;

  // R-type funct values this control unit knows how to execute.
  function automatic logic f_funct_legal(input logic [5:0] funct);
    logic ok;
    case (funct)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: ok = 1'b1;
      default:                           ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Last cycle of a memory state: exit and fire the one-shot strobes.
  always_comb begin
    w_last_wait = (r_wait_cnt == LP_WAIT_LAST);
  end

  // State and wait-counter registers; the illegal flag is sticky until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RST;
      r_wait_cnt <= 4'd0;
      r_illegal  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait;
      if (w_next_state == ST_ILLEGAL) begin
        r_illegal <= 1'b1;
      end else begin
        r_illegal <= r_illegal;
      end
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    w_next_state = r_state;
    w_next_wait  = 4'd0;
    case (r_state)
      ST_RST: w_next_state = ST_FETCH;
      ST_FETCH: begin
        if (w_last_wait) begin
          w_next_state = ST_DECODE;
        end else begin
          w_next_wait = r_wait_cnt + 4'd1;
        end
      end
      ST_DECODE: begin
        case (w_opcode)
          6'h00: begin
            if (f_funct_legal(w_funct)) begin
              w_next_state = ST_R_EXEC;
            end else begin
              w_next_state = ST_ILLEGAL;
            end
          end
          6'h23, 6'h2B: w_next_state = ST_MEM_ADDR;
          6'h08:        w_next_state = ST_ADDI_EXEC;
          6'h04:        w_next_state = ST_BRANCH;
          6'h02:        w_next_state = ST_JUMP;
          default:      w_next_state = ST_ILLEGAL;
        endcase
      end
      ST_MEM_ADDR: begin
        // Only lw and sw reach here; the IR is stable for the whole instruction.
        if (w_opcode == 6'h2B) begin
          w_next_state = ST_MEM_WR;
        end else begin
          w_next_state = ST_MEM_RD;
        end
      end
      ST_MEM_RD: begin
        if (w_last_wait) begin
          w_next_state = ST_LW_WB;
        end else begin
          w_next_wait = r_wait_cnt + 4'd1;
        end
      end
      ST_MEM_WR: begin
        if (w_last_wait) begin
          w_next_state = ST_FETCH;
        end else begin
          w_next_wait = r_wait_cnt + 4'd1;
        end
      end
      ST_LW_WB:     w_next_state = ST_FETCH;
      ST_R_EXEC:    w_next_state = ST_R_WB;
      ST_R_WB:      w_next_state = ST_FETCH;
      ST_ADDI_EXEC: w_next_state = ST_ADDI_WB;
      ST_ADDI_WB:   w_next_state = ST_FETCH;
      ST_BRANCH:    w_next_state = ST_FETCH;
      ST_JUMP:      w_next_state = ST_FETCH;
      ST_ILLEGAL:   w_next_state = ST_ILLEGAL;
      default:      w_next_state = ST_ILLEGAL;
    endcase
  end

  // Moore output decode; one-shot strobes qualified by the final wait cycle.
  always_comb begin
    w_PCWrite     = 1'b0;
    w_PCWriteCond = 1'b0;
    w_IorD        = 1'b0;
    w_MemRead     = 1'b0;
    w_MemWrite    = 1'b0;
    w_IRWrite     = 1'b0;
    w_MDRWrite    = 1'b0;
    w_RegDst      = 1'b0;
    w_MemtoReg    = 1'b0;
    w_RegWrite    = 1'b0;
    w_ALUSrcA     = 2'b00;
    w_ALUSrcB     = 2'b00;
    w_ALUOp       = 2'b00;
    w_PCSource    = 2'b00;
    case (r_state)
      ST_FETCH: begin
        w_MemRead = 1'b1;
        w_ALUSrcB = 2'b01;
        w_IRWrite = w_last_wait;
        w_PCWrite = w_last_wait;
      end
      ST_DECODE: begin
        w_ALUSrcB = 2'b11;
      end
      ST_MEM_ADDR, ST_ADDI_EXEC: begin
        w_ALUSrcA = 2'b01;
        w_ALUSrcB = 2'b10;
      end
      ST_MEM_RD: begin
        w_MemRead  = 1'b1;
        w_IorD     = 1'b1;
        w_MDRWrite = w_last_wait;
      end
      ST_LW_WB: begin
        w_RegWrite = 1'b1;
        w_MemtoReg = 1'b1;
      end
      ST_MEM_WR: begin
        w_IorD     = 1'b1;
        w_MemWrite = w_last_wait;
      end
      ST_R_EXEC: begin
        w_ALUSrcA = 2'b01;
        w_ALUOp   = 2'b10;
      end
      ST_R_WB: begin
        w_RegWrite = 1'b1;
        w_RegDst   = 1'b1;
      end
      ST_ADDI_WB: begin
        w_RegWrite = 1'b1;
      end
      ST_BRANCH: begin
        w_ALUSrcA     = 2'b01;
        w_ALUOp       = 2'b01;
        w_PCWriteCond = 1'b1;
        w_PCSource    = 2'b01;
      end
      ST_JUMP: begin
        w_PCWrite  = 1'b1;
        w_PCSource = 2'b10;
      end
      default: begin
        w_PCWrite = 1'b0;
      end
    endcase
  end

  assign w_illegal = r_illegal;
  assign w_state   = r_state;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle MIPS main control unit. Sequences the shared ALU, PC, instruction register, register file and memory port over several cycles per instruction.
- Drives the ALU-operand mux selects (ALUSrcA/ALUSrcB), the PC source select and all datapath write strobes.
- Sits beside the datapath. Consumes opcode, funct and the ALU zero flag.

Parameters:
- MEM_WAIT, 1, cycles each memory access is held (1..15). Every memory state lasts exactly MEM_WAIT cycles.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- w_opcode  in  6  IR[31:26]
- w_funct  in  6  IR[5:0]; only checked for legality
- w_zero  in  1  ALU zero flag
- w_PCWrite  out  1  unconditional PC load
- w_PCWriteCond  out  1  PC load if w_zero
- w_IorD  out  1  memory address: 0=PC, 1=ALUOut
- w_MemRead  out  1  memory read strobe
- w_MemWrite  out  1  memory write strobe
- w_IRWrite  out  1  instruction register load
- w_MDRWrite  out  1  memory data register load
- w_RegDst  out  1  write reg: 0=rt, 1=rd
- w_MemtoReg  out  1  write data: 0=ALUOut, 1=MDR
- w_RegWrite  out  1  register file write
- w_ALUSrcA  out  2  00=PC, 01=A, 10=SignExtend26→32, 11=MDR
- w_ALUSrcB  out  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
- w_ALUOp  out  2  00=add, 01=sub, 10=decode funct
- w_PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- w_illegal  out  1  sticky illegal-opcode flag
- w_state  out  4  current state code, for debug

Behaviour:
- Moore FSM: 4-bit state register plus 4-bit wait_cnt. All outputs decode from state only. The only exception is that final-cycle strobes are gated by wait_cnt==MEM_WAIT-1.
- Reset (asynchronous): state=RST(0), wait_cnt=0, w_illegal=0. All strobes=0; all selects=00.
- Transitions and per-state outputs. Outputs not listed are 0/00.
  - RST(0): no outputs. Next state is FETCH.
  - FETCH(1): MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=00. On the last wait cycle only, IRWrite=1 and PCWrite=1. Next state is DECODE.
  - DECODE(2): ALUSrcA=00, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
    - 0x00 goes to R_EXEC if funct ∈ {0x20, 0x22, 0x24, 0x25, 0x2A}; otherwise ILLEGAL.
    - 0x23 or 0x2B goes to MEM_ADDR.
    - 0x08 goes to ADDI_EXEC.
    - 0x04 goes to BRANCH.
    - 0x02 goes to JUMP.
    - Any other opcode goes to ILLEGAL.
  - MEM_ADDR(3): ALUSrcA=01, ALUSrcB=10, ALUOp=00. Next state is MEM_RD for 0x23, MEM_WR for 0x2B.
  - MEM_RD(4): MemRead=1, IorD=1. On the last wait cycle, MDRWrite=1. Next state is LW_WB.
  - LW_WB(5): RegWrite=1, RegDst=0, MemtoReg=1. Next state is FETCH.
  - MEM_WR(6): IorD=1. MemWrite=1 on the last wait cycle only (single-cycle write pulse). Next state is FETCH.
  - R_EXEC(7): ALUSrcA=01, ALUSrcB=00, ALUOp=10. Next state is R_WB.
  - R_WB(8): RegWrite=1, RegDst=1, MemtoReg=0. Next state is FETCH.
  - ADDI_EXEC(9): ALUSrcA=01, ALUSrcB=10, ALUOp=00. Next state is ADDI_WB.
  - ADDI_WB(10): RegWrite=1, RegDst=0, MemtoReg=0. Next state is FETCH.
  - BRANCH(11): ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next state is FETCH.
  - JUMP(12): PCWrite=1, PCSource=10. Next state is FETCH.
  - ILLEGAL(13): sets w_illegal=1 and holds there. Only reset exits.
- Memory states (FETCH, MEM_RD, MEM_WR):
  - wait_cnt increments each cycle while in the state.
  - When wait_cnt==MEM_WAIT-1, the state exits and wait_cnt clears to 0.
  - With MEM_WAIT=1 each memory state takes one cycle and the final-cycle strobes coincide with entry.
  - wait_cnt is 0 in all non-memory states.
- Strobe timing:
  - MemRead and IorD are held for the whole memory state.
  - IRWrite, PCWrite (in FETCH), MDRWrite and MemWrite assert for exactly one cycle per instruction.
- Latency in cycles (M = MEM_WAIT):
  - R-type and addi: M+3
  - lw: 2M+3
  - sw: 2M+2
  - beq and j: M+2
- Reset mid-instruction aborts immediately. There are no partial writes after reset assertion, because strobes drop asynchronously with state.
- Unused state codes 14 and 15 go to ILLEGAL next cycle.

Test Plan:
- Assert reset during MEM_WR with MEM_WAIT=3 → w_MemWrite never pulses. After release: one RST cycle, then FETCH, w_illegal=0.
- MEM_WAIT=1, opcode=0x00, funct=0x20 → states 1,2,7,8,1. ALUSrcA=01 and ALUOp=10 in R_EXEC. RegWrite=1 with RegDst=1 for one cycle. 4 cycles total.
- MEM_WAIT=3, opcode=0x23 → FETCH lasts 3 cycles with IRWrite only on the 3rd. MEM_RD lasts 3 cycles with MDRWrite only on the 3rd. LW_WB has MemtoReg=1. 9 cycles total.
- opcode=0x04 with w_zero=1, then again with w_zero=0 → BRANCH shows PCWriteCond=1, PCSource=01, ALUOp=01 both times, and PCWrite=0. DECODE shows ALUSrcB=11.
- opcode=0x2B at MEM_WAIT=2 → exactly one MemWrite pulse with IorD=1, on the 2nd MEM_WR cycle. RegWrite never asserts.
- opcode=0x3F, and separately opcode=0x00 with funct=0x01 → ILLEGAL (13), w_illegal=1 and held. No strobes for 20 cycles. Reset clears the flag.
